// File: rtl/shiftreg_univ_pkg.sv
// rtl/shiftreg_univ_pkg.sv - shared MODE encoding for the universal shift register
package shiftreg_defs;

   localparam int MODE_W = 3;
   typedef logic [MODE_W-1:0] mode_t;

   localparam mode_t MODE_HOLD = 3'd0;
   localparam mode_t MODE_SHR  = 3'd1;
   localparam mode_t MODE_SHL  = 3'd2;
   localparam mode_t MODE_ROR  = 3'd3;
   localparam mode_t MODE_ROL  = 3'd4;
   localparam mode_t MODE_LOAD = 3'd5;
   localparam mode_t MODE_SCLR = 3'd6;

   // Shift and rotate modes all advance the frame counter, whatever the direction.
   function automatic logic is_shift(input mode_t m);
      return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) || (m == MODE_ROL);
   endfunction

endpackage

// File: rtl/shiftreg_univ_shift_cnt.sv
// rtl/shiftreg_univ_shift_cnt.sv - modulo-WIDTH shift counter with one-cycle frame pulse
module shift_cnt #(
   parameter  int WIDTH = 12,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          inc,
   input  logic          zero,
   output logic [CW-1:0] cnt,
   output logic          frame
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // zero has priority so a load landing on the final shift of a frame suppresses the pulse.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         cnt   <= '0;
         frame <= 1'b0;
      end else begin
         frame <= 1'b0;
         if (zero) begin
            cnt <= '0;
         end else if (inc) begin
            if (cnt == LAST) begin
               cnt   <= '0;
               frame <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/shiftreg_univ.sv
// rtl/shiftreg_univ.sv - parametrised universal shift register with frame counter
module shiftreg_univ
   import shiftreg_defs::*;
#(
   parameter  int               WIDTH     = 12,
   parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   localparam int               CW        = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             EN,
   input  logic [2:0]       MODE,
   input  logic             SIN_R,
   input  logic             SIN_L,
   input  logic [WIDTH-1:0] D_PAR,
   output logic [WIDTH-1:0] Q,
   output logic             SOUT_R,
   output logic             SOUT_L,
   output logic [CW-1:0]    CNT,
   output logic             FRAME
);

   logic [WIDTH-1:0] q_next;
   logic             inc;
   logic             zero;

   always_comb begin
      q_next = Q;
      case (MODE)
         MODE_SHR:  q_next = {SIN_R, Q[WIDTH-1:1]};
         MODE_SHL:  q_next = {Q[WIDTH-2:0], SIN_L};
         MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
         MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
         MODE_LOAD: q_next = D_PAR;
         MODE_SCLR: q_next = RESET_VAL;
         default:   q_next = Q;
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR)
         Q <= RESET_VAL;
      else if (EN)
         Q <= q_next;
   end

   assign SOUT_R = Q[0];
   assign SOUT_L = Q[WIDTH-1];

   assign inc  = EN & is_shift(MODE);
   assign zero = EN & ((MODE == MODE_LOAD) || (MODE == MODE_SCLR));

   shift_cnt #(.WIDTH(WIDTH)) u_cnt (
      .CLK   (CLK),
      .CLR   (CLR),
      .inc   (inc),
      .zero  (zero),
      .cnt   (CNT),
      .frame (FRAME)
   );

endmodule

// File: tb/tb_shiftreg_univ.sv
// tb/tb_shiftreg_univ.sv - randomized bench for shiftreg_univ against a behavioural model
module tb_shiftreg_univ;

   localparam int W = 12;

   logic          CLK = 1'b0;
   logic          CLR = 1'b1;
   logic          EN = 1'b0;
   logic [2:0]    MODE = 3'd0;
   logic          SIN_R = 1'b0;
   logic          SIN_L = 1'b0;
   logic [W-1:0]  D_PAR = '0;

   logic [W-1:0]  q0, q1;
   logic          sr0, sl0, sr1, sl1;
   logic [3:0]    cnt0, cnt1;
   logic          fr0, fr1;

   shiftreg_univ #(.WIDTH(W), .RESET_VAL(12'h000)) dut0 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE), .SIN_R(SIN_R), .SIN_L(SIN_L),
      .D_PAR(D_PAR), .Q(q0), .SOUT_R(sr0), .SOUT_L(sl0), .CNT(cnt0), .FRAME(fr0));

   shiftreg_univ #(.WIDTH(W), .RESET_VAL(12'h0F0)) dut1 (
      .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE), .SIN_R(SIN_R), .SIN_L(SIN_L),
      .D_PAR(D_PAR), .Q(q1), .SOUT_R(sr1), .SOUT_L(sl1), .CNT(cnt1), .FRAME(fr1));

   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: word as an integer, count as total shifts since the last load/clear.
   int mq[2];
   int rv[2] = '{32'h000, 32'h0F0};
   int mn;
   bit mframe;

   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < 2; i++) mq[i] = rv[i];
         mn = 0;
         mframe = 0;
      end else begin
         mframe = 0;
         if (EN) begin
            for (int i = 0; i < 2; i++) begin
               case (MODE)
                  3'd1: mq[i] = (mq[i] >> 1) | (int'(SIN_R) << (W - 1));
                  3'd2: mq[i] = ((mq[i] << 1) & 'hFFF) | int'(SIN_L);
                  3'd3: mq[i] = (mq[i] >> 1) | ((mq[i] & 1) << (W - 1));
                  3'd4: mq[i] = ((mq[i] << 1) & 'hFFF) | (mq[i] >> (W - 1));
                  3'd5: mq[i] = int'(D_PAR);
                  3'd6: mq[i] = rv[i];
                  default: ;
               endcase
            end
            if (MODE >= 3'd1 && MODE <= 3'd4) begin
               mn++;
               if (mn % W == 0) mframe = 1;
            end else if (MODE == 3'd5 || MODE == 3'd6) begin
               mn = 0;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en && !CLR) begin
         chk("q0", int'(q0), mq[0]);
         chk("q1", int'(q1), mq[1]);
         chk("sout_r0", int'(sr0), mq[0] & 1);
         chk("sout_l0", int'(sl0), mq[0] >> (W - 1));
         chk("sout_r1", int'(sr1), mq[1] & 1);
         chk("sout_l1", int'(sl1), mq[1] >> (W - 1));
         chk("cnt0", int'(cnt0), mn % W);
         chk("cnt1", int'(cnt1), mn % W);
         chk("frame0", int'(fr0), int'(mframe));
         chk("frame1", int'(fr1), int'(mframe));
      end
   end

   task automatic step(input bit en, input int mode, input bit sr, input bit sl, input int d);
      EN = en;
      MODE = 3'(mode);
      SIN_R = sr;
      SIN_L = sl;
      D_PAR = W'(d);
      @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      CLR = 1'b0;
      chk_en = 1;
      #1;
      chk("rst_q0", int'(q0), 'h000);
      chk("rst_q1", int'(q1), 'h0F0);
      chk("rst_cnt", int'(cnt0), 0);
      chk("rst_frame", int'(fr0), 0);

      // Asynchronous clear with no clock edge while LOAD of all-ones is pending.
      step(1, 5, 0, 0, 'hFFF);
      chk("load_fff", int'(q0), 'hFFF);
      CLR = 1'b1;
      #1;
      chk("aclr_q0", int'(q0), 'h000);
      chk("aclr_q1", int'(q1), 'h0F0);
      chk("aclr_cnt", int'(cnt0), 0);
      chk("aclr_frame", int'(fr0), 0);
      #1 CLR = 1'b0;
      MODE = 3'd0;

      for (int k = 1; k <= W; k++) begin
         step(1, 1, 1, 0, 0);
         chk("fill_q", int'(q0), ((1 << k) - 1) << (W - k));
         chk("fill_cnt", int'(cnt0), k % W);
         chk("fill_frame", int'(fr0), (k == W) ? 1 : 0);
      end
      chk("fill_model", mq[0], 'hFFF);
      step(1, 0, 0, 0, 0);
      chk("frame_one_cycle", int'(fr0), 0);

      step(1, 5, 0, 0, 'hA5C);
      repeat (4) step(1, 4, 0, 0, 0);
      chk("rol_q", int'(q0), 'h5CA);
      chk("rol_model", mq[0], 'h5CA);
      chk("rol_soutl", int'(sl0), 0);
      chk("rol_cnt", int'(cnt0), 4);

      step(1, 5, 0, 0, 'h001);
      repeat (3) step(1, 2, 0, 0, 0);
      chk("shl_q", int'(q0), 'h008);
      for (int k = 0; k < 5; k++) begin
         step(0, $urandom_range(0, 7), 1'($urandom), 1'($urandom), int'($urandom));
         chk("en0_q", int'(q0), 'h008);
         chk("en0_cnt", int'(cnt0), 3);
         chk("en0_frame", int'(fr0), 0);
      end

      step(1, 5, 0, 0, 'h000);
      repeat (11) step(1, 1, 0, 0, 0);
      chk("pre_load_cnt", int'(cnt0), 11);
      step(1, 5, 0, 0, 'h123);
      chk("loadwin_q", int'(q0), 'h123);
      chk("loadwin_cnt", int'(cnt0), 0);
      chk("loadwin_frame", int'(fr0), 0);
      step(1, 0, 0, 0, 0);
      chk("loadwin_frame2", int'(fr0), 0);

      repeat (7) step(1, 1, 1, 0, 0);
      chk("pre_clr_cnt", int'(cnt0), 7);
      CLR = 1'b1;
      #2 CLR = 1'b0;
      for (int k = 0; k < W; k++) begin
         step(1, 0, 0, 0, 0);
         chk("abort_frame", int'(fr0), 0);
      end
      chk("abort_cnt", int'(cnt0), 0);
      chk("abort_q", int'(q0), 'h000);

      repeat (3) step(1, 1, 1, 0, 0);
      for (int k = 0; k < 6; k++) begin
         step(1, (k % 2) ? 7 : 0, 1'($urandom), 1'($urandom), int'($urandom));
         chk("hold_q", int'(q0), 'hE00);
         chk("hold_cnt", int'(cnt0), 3);
      end

      step(1, 5, 0, 0, 'hABC);
      step(1, 6, 0, 0, 0);
      chk("sclr_q1", int'(q1), 'h0F0);
      chk("sclr_q0", int'(q0), 'h000);
      chk("sclr_cnt", int'(cnt1), 0);

      for (int k = 0; k < 3000; k++) begin
         int m;
         m = $urandom_range(0, 10);
         if (m > 7) m = $urandom_range(1, 4);
         step(($urandom_range(0, 7) != 0), m, 1'($urandom), 1'($urandom), int'($urandom));
         if ($urandom_range(0, 199) == 0) begin
            CLR = 1'b1;
            #1 CLR = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/shiftreg_univ.md
# shiftreg_univ

Parametrised universal shift register: the successor to the fixed 12-bit serial-in shift register, used wherever the 1-bit datapath serialises or deserialises words (operand capture, output display, I/O). Adds configurable width, bidirectional shift, rotate, parallel load, synchronous clear, clock enable, and a shift counter. The counter flags each completed frame of WIDTH shifts. With MODE=SHR and EN=1 it is cycle-identical to the legacy block: D enters the MSB and moves toward the LSB.

## Interface
- WIDTH, 12: register length in bits, ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into Q by CLR and by SCLR.
- CLK  in  1  clock; all state updates on its rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- EN  in  1  clock enable; when 0, every register holds.
- MODE  in  3  operation select (encoding below).
- SIN_R  in  1  serial input for right shift; enters Q[WIDTH-1].
- SIN_L  in  1  serial input for left shift; enters Q[0].
- D_PAR  in  WIDTH  parallel load data.
- Q  out  WIDTH  register contents.
- SOUT_R  out  1  Q[0], combinational from Q.
- SOUT_L  out  1  Q[WIDTH-1], combinational from Q.
- CNT  out  CW  shifts since last load/clear; CW = $clog2(WIDTH+1).
- FRAME  out  1  registered one-cycle pulse when CNT reaches WIDTH.

## Operation
- Reset (CLR=1): Q=RESET_VAL, CNT=0, FRAME=0. Takes effect immediately and overrides CLK, EN and MODE. Release is synchronous to the next edge.
- MODE encoding:
  - 0 HOLD: no change.
  - 1 SHR: Q <= {SIN_R, Q[W-1:1]}.
  - 2 SHL: Q <= {Q[W-2:0], SIN_L}.
  - 3 ROR: Q <= {Q[0], Q[W-1:1]}.
  - 4 ROL: Q <= {Q[W-2:0], Q[W-1]}.
  - 5 LOAD: Q <= D_PAR.
  - 6 SCLR: Q <= RESET_VAL.
  - 7 reserved, behaves as HOLD.
- Counting: modes 1–4 are shift modes and increment CNT. LOAD and SCLR set CNT=0. HOLD and reserved leave CNT unchanged.
- Wrap-around: a shift edge with CNT=WIDTH-1 sets CNT=0 (never holds the value WIDTH) and sets FRAME=1 for the next cycle.
- FRAME is 0 after every other edge, including edges with EN=0.
- EN=0: Q and CNT hold; FRAME clears on the next edge.
- Direction changes mid-frame still count; CNT is direction-agnostic.

## Timing
- Q, CNT and FRAME are all registered; latency is one CLK edge from inputs to Q.
- SOUT_R and SOUT_L follow Q combinationally; no extra stage.
- FRAME rises on the same edge that shifts the WIDTH-th bit in and lasts exactly one cycle. Consecutive frames give a pulse every WIDTH enabled shift cycles.
- CLR asserted mid-frame aborts the frame: CNT=0, no FRAME pulse, and the partial word is lost.
- LOAD on an edge that would have been the WIDTH-th shift: LOAD wins, CNT=0, FRAME=0.

## Structure
- Shared package/include `shiftreg_defs`: MODE width and localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_LOAD, MODE_SCLR.
- Sub-module `shift_cnt`:
  - Parameter: WIDTH.
  - Inputs: CLK, CLR, inc, zero.
  - Outputs: cnt, frame.
  - Holds the modulo-WIDTH counter and the FRAME pulse.
- Top level holds the Q register and the mode mux, and drives shift_cnt.

## Test plan
- CLR pulse while MODE=LOAD and D_PAR=12'hFFF, with no clock edge → Q=000, CNT=0, FRAME=0 immediately.
- WIDTH=12, MODE=SHR, SIN_R=1 for 12 edges → Q fills 800, C00, … FFF; CNT counts 1..11 then 0; FRAME high only in the cycle after edge 12.
- LOAD 12'hA5C, then ROL ×4 → Q=5CA, SOUT_L=0, CNT=4.
- LOAD 12'h001, then SHL with SIN_L=0 ×3 → Q=008. Then EN=0 for 5 cycles → Q=008 and CNT=3 held, FRAME=0.
- SHR ×11 (CNT=11), then LOAD on edge 12 → Q=D_PAR, CNT=0, no FRAME pulse. Separately, CLR at CNT=7 → CNT=0, no pulse.
- MODE=7 and MODE=0 with random SIN/D_PAR → Q and CNT unchanged. SCLR with RESET_VAL=12'h0F0 → Q=0F0, CNT=0.
